// File: rtl/uart_rx_engine.sv
`timescale 1ns/1ps
// uart_rx_engine
// Receive half of the UART. Deserialises an asynchronous serial line framed as
// start / 7 or 8 data bits LSB-first / optional parity / stop, checks parity
// and stop, and holds the received byte for the host together with status flags.
//
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   rx_i       serial line, idle high (mark)
//   k_i        clocks per bit time (>= 4), stable while busy
//   eight_i    1 = 8 data bits, 0 = 7 data bits
//   pen_i      1 = parity bit present
//   ohel_i     parity sense when pen_i=1: 1 = odd, 0 = even
//   read_i     one-clock host read strobe; clears rxrdy and error flags
//   rx_data_o  received byte, right-justified (bit7 = 0 in 7-bit mode)
//   rxrdy_o    a new byte is valid
//   perr_o     parity error on the held byte
//   ferr_o     framing error (stop bit sampled 0)
//   ovf_o      overrun: new byte loaded while rxrdy was still set
//   busy_o     a frame is in progress
module uart_rx_engine #(
    parameter int unsigned BAUD_W = 19
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_i,
    input  logic [BAUD_W-1:0] k_i,
    input  logic              eight_i,
    input  logic              pen_i,
    input  logic              ohel_i,
    input  logic              read_i,
    output logic [7:0]        rx_data_o,
    output logic              rxrdy_o,
    output logic              perr_o,
    output logic              ferr_o,
    output logic              ovf_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_LOAD
    } state_e;

    state_e            state_q;
    logic              sync1_q;
    logic              rxs_q;
    logic [BAUD_W-1:0] btc_q;
    logic [3:0]        bc_q;
    logic [9:0]        sr_q;
    logic [7:0]        rx_data_q;
    logic              rxrdy_q;
    logic              perr_q;
    logic              ferr_q;
    logic              ovf_q;

    logic [3:0]        n_d;
    logic [3:0]        bc_inc_d;
    logic [BAUD_W-1:0] half_k_d;
    logic [BAUD_W-1:0] kmax_d;
    logic [8:0]        word_d;
    logic [7:0]        data_d;
    logic              par_d;
    logic              exp_par_d;
    logic              stop_d;

    always_comb begin
        n_d       = 4'd8 + {3'b000, eight_i} + {3'b000, pen_i};
        bc_inc_d  = bc_q + 4'd1;
        half_k_d  = k_i >> 1;
        kmax_d    = k_i - BAUD_W'(1);
        // The stop bit is always the last sample, so it sits in sr_q[9]. Only
        // sr_q[8:0] is right-justified: any word bit that would come from
        // sr_q[9] is either the stop bit or a parity bit masked by pen_i=0.
        word_d    = sr_q[8:0] >> (4'd10 - n_d);
        data_d    = eight_i ? word_d[7:0] : {1'b0, word_d[6:0]};
        par_d     = eight_i ? word_d[8] : word_d[7];
        exp_par_d = ohel_i ? ~^data_d : ^data_d;
        stop_d    = sr_q[9];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b1;
            rxs_q     <= 1'b1;
            btc_q     <= '0;
            bc_q      <= '0;
            sr_q      <= '0;
            rx_data_q <= '0;
            rxrdy_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            rxs_q   <= sync1_q;

            // A load in the same clock overrides these clears below.
            if (read_i) begin
                rxrdy_q <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end

            // Magnitude compares (>=) keep the FSM moving even if k/framing
            // controls change mid-frame.
            case (state_q)
                S_IDLE: begin
                    if (!rxs_q) begin
                        state_q <= S_START;
                        btc_q   <= '0;
                    end
                end
                S_START: begin
                    if (btc_q >= half_k_d) begin
                        if (rxs_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_DATA;
                            btc_q   <= '0;
                            bc_q    <= '0;
                        end
                    end else begin
                        btc_q <= btc_q + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (btc_q >= kmax_d) begin
                        sr_q  <= {rxs_q, sr_q[9:1]};
                        btc_q <= '0;
                        bc_q  <= bc_inc_d;
                        if (bc_inc_d >= n_d) begin
                            state_q <= S_LOAD;
                        end
                    end else begin
                        btc_q <= btc_q + BAUD_W'(1);
                    end
                end
                S_LOAD: begin
                    rx_data_q <= data_d;
                    rxrdy_q   <= 1'b1;
                    perr_q    <= pen_i & (par_d != exp_par_d);
                    ferr_q    <= ~stop_d;
                    ovf_q     <= rxrdy_q & ~read_i;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_data_o = rx_data_q;
    assign rxrdy_o   = rxrdy_q;
    assign perr_o    = perr_q;
    assign ferr_o    = ferr_q;
    assign ovf_o     = ovf_q;
    assign busy_o    = (state_q != S_IDLE);

endmodule
